// File: rtl/expon_arbiter_if.sv
// Requester and engine-side signals of the shared e^x engine arbiter.
// The arbiter takes the slave view; the requesters/engine environment takes the master view.
interface expon_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]    req;
   logic [NREQ*32-1:0] req_x;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic [31:0]        y;
   logic               err;
   logic               busy;
   logic [31:0]        eng_x;
   logic               eng_start;
   logic               eng_done;
   logic [31:0]        eng_y;

   modport master (
      output req, req_x, eng_done, eng_y,
      input  gnt, done, y, err, busy, eng_x, eng_start
   );

   modport slave (
      input  req, req_x, eng_done, eng_y,
      output gnt, done, y, err, busy, eng_x, eng_start
   );
endinterface

// File: rtl/expon_arbiter.sv
// Round-robin arbiter that serialises NREQ requesters onto one exponential engine:
// grant, issue a start pulse, wait for the result (bounded by TIMEOUT), return it.
module expon_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16,
   parameter int TW      = 5
) (
   input logic            clk,
   input logic            res,
   expon_arbiter_if.slave bus
);
   localparam int              IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IW-1:0]   LAST_IDX  = IW'(NREQ - 1);
   localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMEOUT - 1);
   localparam logic [NREQ-1:0] ONE       = NREQ'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state;
   logic [NREQ-1:0] gnt_q;
   logic [NREQ-1:0] done_q;
   logic [NREQ-1:0] mask;
   logic [31:0]     y_q;
   logic [31:0]     eng_x_q;
   logic            err_q;
   logic            busy_q;
   logic            eng_start_q;
   logic [TW-1:0]   timer;
   logic [IW-1:0]   last;
   logic [IW-1:0]   sel;

   logic [NREQ-1:0] eff;
   logic            pick_valid;
   logic [IW-1:0]   pick;
   logic [IW-1:0]   cand;
   logic [31:0]     x_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_x
      assign x_arr[i] = bus.req_x[32*i +: 32];
   end

   // Search starts just after the last winner and wraps, giving round-robin order.
   // NOTE: every variable gets a default before the loop so no latch can be inferred.
   always_comb begin
      eff        = bus.req & ~mask;
      pick_valid = 1'b0;
      pick       = '0;
      cand       = last;
      for (int k = 0; k < NREQ; k++) begin
         cand = (cand == LAST_IDX) ? '0 : cand + IW'(1);
         if (!pick_valid && eff[cand]) begin
            pick_valid = 1'b1;
            pick       = cand;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (res) begin
         state       <= IDLE;
         gnt_q       <= '0;
         done_q      <= '0;
         mask        <= '0;
         y_q         <= '0;
         eng_x_q     <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         eng_start_q <= 1'b0;
         timer       <= '0;
         last        <= LAST_IDX;
         sel         <= '0;
      end else begin
         case (state)
            IDLE: begin
               mask <= '0;
               if (pick_valid) begin
                  sel         <= pick;
                  gnt_q       <= ONE << pick;
                  eng_x_q     <= x_arr[pick];
                  eng_start_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               eng_start_q <= 1'b0;
               timer       <= '0;
               state       <= WAIT;
            end
            WAIT: begin
               timer <= timer + TW'(1);
               // A result arriving on the last allowed cycle still counts as success.
               if (bus.eng_done) begin
                  y_q    <= bus.eng_y;
                  err_q  <= 1'b0;
                  done_q <= gnt_q;
                  state  <= RESP;
               end else if (timer == TIMER_MAX) begin
                  y_q    <= '0;
                  err_q  <= 1'b1;
                  done_q <= gnt_q;
                  state  <= RESP;
               end
            end
            RESP: begin
               done_q <= '0;
               gnt_q  <= '0;
               err_q  <= 1'b0;
               busy_q <= 1'b0;
               last   <= sel;
               // Blocks the winner for one IDLE cycle so a late-dropped req is not re-granted.
               mask   <= gnt_q;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.done      = done_q;
   assign bus.y         = y_q;
   assign bus.err       = err_q;
   assign bus.busy      = busy_q;
   assign bus.eng_x     = eng_x_q;
   assign bus.eng_start = eng_start_q;
endmodule

// File: tb/tb_expon_arbiter.sv
// Self-checking bench for expon_arbiter: behavioural engine, transaction-level round-robin
// model and randomized requesters; prints one summary line at the end.
module tb_expon_arbiter;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;
   localparam int TW      = 5;

   logic clk = 1'b0;
   logic res = 1'b1;
   always #5 clk = ~clk;

   expon_arbiter_if #(.NREQ(NREQ)) bus ();

   expon_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   // Engine model: answers eng_lat cycles after a start pulse; eng_lat=0 means never.
   int          eng_lat = 0;
   logic [31:0] eng_val = '0;
   int          eng_cnt = 0;

   // Reference model state: last winner and the one-cycle post-response block.
   int              model_last = NREQ - 1;
   logic [NREQ-1:0] mask_now   = '0;
   logic [NREQ-1:0] mask_pend  = '0;

   int n_start = 0;
   int n_done  = 0;
   int n_multi = 0;

   initial begin
      bus.eng_done = 1'b0;
      bus.eng_y    = '0;
      forever begin
         @(posedge clk);
         #2;
         bus.eng_done = 1'b0;
         bus.eng_y    = $urandom;
         if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               bus.eng_done = 1'b1;
               bus.eng_y    = eng_val;
            end
         end
         if (bus.eng_start === 1'b1 && eng_lat > 0) eng_cnt = eng_lat;
      end
   end

   always @(negedge clk) begin
      if (bus.eng_start === 1'b1) n_start++;
      if (bus.done !== '0) n_done++;
      if ($countones(bus.gnt) > 1) n_multi++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      mask_now  = mask_pend;
      mask_pend = '0;
   endtask

   task automatic apply_reset();
      res     = 1'b1;
      bus.req = '0;
      tick();
      tick();
      res        = 1'b0;
      model_last = NREQ - 1;
      mask_now   = '0;
      mask_pend  = '0;
   endtask

   // One full transaction: waits for the grant, checks issue, response timing and payload.
   task automatic do_txn(input int lat, input logic [31:0] val, input bit drop,
                         input string tag, output int g, output int waited);
      logic [NREQ-1:0] dec;
      logic [NREQ-1:0] ogh;
      logic [31:0]     ex;
      logic [31:0]     exp_y;
      logic            exp_err;
      int              exp_d;
      int              k;
      int              starts;
      bit              unstable;
      bit              seen;
      eng_lat = lat;
      eng_val = val;
      g       = -1;
      waited  = 0;
      seen    = 1'b0;
      dec     = '0;
      for (int n = 0; n < 40 && !seen; n++) begin
         dec = bus.req & ~mask_now;
         tick();
         if (bus.gnt !== '0) begin
            seen   = 1'b1;
            waited = n;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s grant: gnt stayed %b for 40 cycles, required a grant (req=%b)", tag, bus.gnt, bus.req);
         return;
      end
      g   = rr_pick(dec, model_last);
      ogh = (g < 0) ? '0 : (NREQ'(1) << g);
      total++;
      if (bus.gnt !== ogh) begin
         bad++;
         $display("FAIL %s gnt: got %b, required %b (eligible=%b last=%0d)", tag, bus.gnt, ogh, dec, model_last);
      end
      if (g < 0) return;
      ex = bus.req_x[32*g +: 32];
      total++;
      if (bus.eng_start !== 1'b1 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL %s issue: eng_start=%b busy=%b, required 1 1", tag, bus.eng_start, bus.busy);
      end
      total++;
      if (bus.eng_x !== ex) begin
         bad++;
         $display("FAIL %s eng_x: got %h, required %h", tag, bus.eng_x, ex);
      end

      exp_d   = (lat >= 1 && lat <= TIMEOUT) ? lat + 1 : TIMEOUT + 1;
      exp_err = !(lat >= 1 && lat <= TIMEOUT);
      exp_y   = exp_err ? 32'h0 : val;
      starts   = 0;
      unstable = 1'b0;
      for (k = 1; k <= 40; k++) begin
         tick();
         if (bus.eng_start !== 1'b0) starts++;
         if (bus.gnt !== ogh || bus.eng_x !== ex || bus.busy !== 1'b1) unstable = 1'b1;
         if (bus.done !== '0) break;
      end
      total++;
      if (k != exp_d) begin
         bad++;
         $display("FAIL %s latency: done %0d cycles after grant, required %0d", tag, k, exp_d);
      end
      total++;
      if (bus.done !== ogh) begin
         bad++;
         $display("FAIL %s done: got %b, required %b", tag, bus.done, ogh);
      end
      total++;
      if (bus.y !== exp_y || bus.err !== exp_err) begin
         bad++;
         $display("FAIL %s result: y=%h err=%b, required y=%h err=%b", tag, bus.y, bus.err, exp_y, exp_err);
      end
      total++;
      if (starts != 0 || unstable) begin
         bad++;
         $display("FAIL %s hold: extra starts=%0d unstable=%0b, required 0 0", tag, starts, unstable);
      end

      model_last = g;
      mask_pend  = ogh;
      if (drop) bus.req[g] = 1'b0;
      tick();
      total++;
      if ({bus.done, bus.gnt, bus.err, bus.busy, bus.eng_start} !== '0 || bus.y !== exp_y) begin
         bad++;
         $display("FAIL %s idle: done=%b gnt=%b err=%b busy=%b start=%b y=%h, required zeros and y=%h",
                  tag, bus.done, bus.gnt, bus.err, bus.busy, bus.eng_start, bus.y, exp_y);
      end
   endtask

   task automatic test_reset();
      bus.req   = '0;
      bus.req_x = '0;
      apply_reset();
      total++;
      if ({bus.gnt, bus.done, bus.err, bus.busy, bus.eng_start} !== '0) begin
         bad++;
         $display("FAIL reset ctrl: gnt=%b done=%b err=%b busy=%b start=%b, required all 0",
                  bus.gnt, bus.done, bus.err, bus.busy, bus.eng_start);
      end
      total++;
      if (bus.y !== 32'h0 || bus.eng_x !== 32'h0) begin
         bad++;
         $display("FAIL reset data: y=%h eng_x=%h, required 0 0", bus.y, bus.eng_x);
      end
   endtask

   task automatic test_single();
      int g, w, s0;
      s0 = n_start;
      bus.req_x[31:0] = 32'h1000_0000;
      bus.req         = 4'b0001;
      do_txn(10, 32'h2B7E_1516, 1'b1, "single", g, w);
      total++;
      if (g != 0 || n_start - s0 != 1) begin
         bad++;
         $display("FAIL single winner: g=%0d starts=%0d, required 0 1", g, n_start - s0);
      end
   endtask

   task automatic test_contention();
      int g, w, s0, d0, m0;
      apply_reset();
      for (int i = 0; i < NREQ; i++) bus.req_x[32*i +: 32] = $urandom;
      bus.req = '1;
      s0 = n_start;
      d0 = n_done;
      m0 = n_multi;
      for (int i = 0; i < 2 * NREQ + 1; i++) begin
         do_txn($urandom_range(1, 12), $urandom, 1'b1, "contend", g, w);
         total++;
         if (g != i % NREQ) begin
            bad++;
            $display("FAIL contend order: grant %0d went to %0d, required %0d", i, g, i % NREQ);
         end
         if (g >= 0) bus.req[g] = 1'b1;
      end
      bus.req = '0;
      tick();
      total++;
      if (n_start - s0 != n_done - d0 || n_multi != m0) begin
         bad++;
         $display("FAIL contend counts: starts=%0d dones=%0d multi_gnt=%0d, required equal and 0",
                  n_start - s0, n_done - d0, n_multi - m0);
      end
   endtask

   task automatic test_late_drop();
      int  g, w;
      bit  regrant;
      bus.req_x[64 +: 32] = $urandom;
      bus.req = 4'b0100;
      do_txn(10, $urandom, 1'b0, "late_drop", g, w);
      tick();
      bus.req = '0;
      regrant = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bus.gnt !== '0 || bus.busy !== 1'b0) regrant = 1'b1;
         tick();
      end
      total++;
      if (g != 2 || regrant) begin
         bad++;
         $display("FAIL late_drop block: g=%0d regrant=%0b, required 2 0", g, regrant);
      end
      bus.req = 4'b0100;
      do_txn(7, $urandom, 1'b0, "held_a", g, w);
      do_txn(7, $urandom, 1'b0, "held_b", g, w);
      bus.req = '0;
      total++;
      if (g != 2 || w != 1) begin
         bad++;
         $display("FAIL late_drop held: g=%0d waited=%0d, required 2 1", g, w);
      end
      tick();
   endtask

   task automatic test_timeout();
      int g, w;
      bus.req_x[32 +: 32] = $urandom;
      bus.req = 4'b0010;
      do_txn(0, $urandom, 1'b1, "timeout", g, w);
      bus.req = 4'b0010;
      do_txn(TIMEOUT + 1, $urandom, 1'b1, "just_late", g, w);
      bus.req = 4'b0010;
      do_txn(5, $urandom, 1'b1, "after_timeout", g, w);
      bus.req = 4'b0001;
      do_txn(TIMEOUT, $urandom, 1'b1, "simultaneous", g, w);
      tick();
   endtask

   task automatic test_reset_mid_wait();
      int g, w;
      bit quiet;
      bus.req_x[64 +: 32] = $urandom;
      bus.req = 4'b0100;
      eng_lat = 12;
      eng_val = 32'hDEAD_BEEF;
      for (int i = 0; i < 20 && bus.gnt === '0; i++) tick();
      repeat (4) tick();
      res     = 1'b1;
      bus.req = '0;
      tick();
      res        = 1'b0;
      model_last = NREQ - 1;
      mask_now   = '0;
      mask_pend  = '0;
      total++;
      if ({bus.busy, bus.gnt, bus.done, bus.eng_start} !== '0) begin
         bad++;
         $display("FAIL reset_mid busy=%b gnt=%b done=%b start=%b, required all 0",
                  bus.busy, bus.gnt, bus.done, bus.eng_start);
      end
      quiet = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.done !== '0 || bus.busy !== 1'b0 || bus.gnt !== '0) quiet = 1'b0;
      end
      total++;
      if (!quiet) begin
         bad++;
         $display("FAIL reset_mid stray: done=%b busy=%b after stray eng_done, required quiet", bus.done, bus.busy);
      end
      for (int i = 0; i < NREQ; i++) bus.req_x[32*i +: 32] = $urandom;
      bus.req = '1;
      do_txn(9, $urandom, 1'b1, "post_reset", g, w);
      bus.req = '0;
      total++;
      if (g != 0) begin
         bad++;
         $display("FAIL post_reset winner: got %0d, required 0", g);
      end
      tick();
   endtask

   task automatic test_random();
      int g, w, r, lat;
      for (int round = 0; round < 30; round++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
               bus.req_x[32*i +: 32] = $urandom;
               bus.req[i]            = 1'b1;
            end
         end
         if (bus.req == '0) begin
            r = $urandom_range(0, NREQ - 1);
            bus.req_x[32*r +: 32] = $urandom;
            bus.req[r]            = 1'b1;
         end
         r = $urandom_range(0, 9);
         if (r == 0)      lat = 0;
         else if (r == 1) lat = $urandom_range(TIMEOUT, TIMEOUT + 2);
         else             lat = $urandom_range(1, 14);
         do_txn(lat, $urandom, $urandom_range(0, 3) != 0, "random", g, w);
      end
      bus.req = '0;
      repeat (3) tick();
   endtask

   initial begin
      bus.req   = '0;
      bus.req_x = '0;
      test_reset();
      test_single();
      test_contention();
      test_late_drop();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/expon_arbiter.md
Name: expon_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one exponential (Taylor-series) engine among NREQ requesters.
- Accepts one request at a time, latches that requester's 32-bit operand into the engine and pulses the engine start.
- Waits for the engine result (with timeout), then returns the result and a one-cycle done to the granted requester.
- Sits between the requesting datapaths and the single e^x engine, which is itself sequenced by its own controller.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 16, maximum WAIT cycles before abort; must be ≥ engine latency (10).
- TW, 5, timer width; 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on posedge.
- res  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester request level; held high until that requester's done.
- req_x  in  NREQ*32  operands; requester i uses bits [32i+31:32i], Q4.28.
- gnt  out  NREQ  one-hot grant; high from ISSUE through RESP.
- done  out  NREQ  one-cycle completion pulse to the granted requester.
- y  out  32  result; valid while any done bit is high, otherwise holds last value.
- err  out  1  high with done when the transaction timed out; y=0 in that case.
- busy  out  1  high whenever state ≠ IDLE.
- eng_x  out  32  operand to engine; stable from ISSUE until next grant.
- eng_start  out  1  one-cycle start pulse to engine.
- eng_done  in  1  engine result-valid pulse.
- eng_y  in  32  engine result, sampled when eng_done=1.

Behaviour:
- All outputs registered.
- Reset (res=1 at posedge, any state including mid-transaction): state=IDLE; gnt=0, done=0, err=0, busy=0, eng_start=0, y=0, eng_x=0, timer=0, mask=0, last=NREQ-1 (requester 0 has first priority).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - eff = req & ~mask.
  - If eff≠0, winner g = first set bit searching last+1, last+2, … modulo NREQ.
  - Latch eng_x=req_x[g], gnt=one-hot(g), go ISSUE.
  - mask clears every IDLE cycle.
- ISSUE (exactly 1 cycle): eng_start=1, timer=0, go WAIT.
- WAIT:
  - eng_start=0; timer increments each cycle.
  - eng_done=1 → y=eng_y, err=0, go RESP.
  - Else if timer==TIMEOUT-1 → y=0, err=1, go RESP.
  - eng_done and timeout in the same cycle: eng_done wins, err=0.
- RESP (exactly 1 cycle):
  - done[g]=1, y/err valid; last=g; mask=one-hot(g).
  - Go IDLE; gnt and done clear on entry to IDLE.
  - mask blocks g only for the single IDLE cycle after RESP, so a requester that drops req one cycle late is not re-granted.
- eng_done outside WAIT is ignored.
- eng_y is sampled only in WAIT.
- req dropping mid-transaction: the transaction still completes and done still pulses; no cancel.
- Latency: req high in IDLE at cycle T → eng_start at T+1 → WAIT from T+2 → eng_done at cycle D → done at D+1.
- Minimum occupancy is 4 cycles.
- Fairness: with all req held high, grants rotate 0,1,2,…,NREQ-1,0.

Test Plan:
- Single request: req=0001, x0=0x10000000, engine model returns 0x2B7E1516 after 10 cycles → gnt=0001, one eng_start, eng_x=0x10000000, done=0001 one cycle with y=0x2B7E1516, err=0.
- Full contention: req=1111 held, each requester re-raises req after its done → grant order 0,1,2,3,0; exactly one gnt bit at a time; eng_start count equals done count.
- Late drop: requester 2 alone, keeps req high one cycle after done → not re-granted in that IDLE cycle; granted again only if req still high in the following IDLE cycle.
- Timeout: engine never asserts eng_done → done pulses 16 cycles after WAIT entry with err=1, y=0; next request proceeds normally.
- Simultaneous events: eng_done asserted at timer==TIMEOUT-1 → err=0, y=eng_y.
- Reset mid-WAIT: res=1 → next cycle busy=0, gnt=0, no done; a stray eng_done afterwards is ignored; the next grant goes to requester 0 if requesting.
